// File: rtl/sub3_lane_fifo.sv
// sub3_lane_fifo: DEPTH-entry show-ahead valid/ready FIFO carrying a packed
// multi-lane payload and an unpacked sideband payload. Each entry is
// lane-transformed (pass / reverse / rotate / broadcast) when it is pushed.
// Status outputs (ready, valid, occupancy, almost-full) come only from the
// registered count, so there is no combinational path from i_sig_rdy.
module sub3_lane_fifo #(
  parameter int NUM_LANES = 3,
  parameter int LANE_W    = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = 3
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_sig_vld,
  output logic                                 o_sig_rdy,
  input  logic [1:0]                           i_sig_mode,
  input  logic [0:NUM_LANES-1][LANE_W-1:0]     i_sig_pkd,
  input  logic [LANE_W-1:0]                    i_sig_upk [0:NUM_LANES-1],
  output logic                                 o_sig_vld,
  input  logic                                 i_sig_rdy,
  output logic [0:NUM_LANES-1][LANE_W-1:0]     o_sig_pkd,
  output logic [LANE_W-1:0]                    o_sig_upk [0:NUM_LANES-1],
  output logic [$clog2(DEPTH+1)-1:0]           o_sig_cnt,
  output logic                                 o_sig_afull
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(NUM_LANES);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);
  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_REV   = 2'd1;
  localparam logic [1:0] MODE_ROT   = 2'd2;

  typedef logic [0:NUM_LANES-1][LANE_W-1:0] lanes_t;

  // Storage is intentionally left unreset; only the pointers and count are.
  lanes_t            mem_pkd [0:DEPTH-1];
  logic [LANE_W-1:0] mem_upk [0:DEPTH-1][0:NUM_LANES-1];

  lanes_t            xf_pkd;
  logic [LANE_W-1:0] xf_upk [0:NUM_LANES-1];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          head_vld;
  logic          push;
  logic          pop;

  assign head_vld    = (count != '0);
  assign o_sig_vld   = head_vld;
  assign o_sig_rdy   = (count < DEPTH_C);
  assign o_sig_afull = (count >= AFULL_C);
  assign o_sig_cnt   = count;

  // A full FIFO refuses the push even if a pop happens in the same cycle.
  assign push = i_sig_vld && o_sig_rdy;
  assign pop  = head_vld && i_sig_rdy;

  // Per-lane source selection for the push-time transform, plus the gated
  // show-ahead outputs (zero whenever the FIFO is empty, so stale or unknown
  // storage never reaches the ports).
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [LW-1:0] src;

    // Pick which input lane feeds output lane k for the current mode.
    always_comb begin
      case (i_sig_mode)
        MODE_PASS: src = LW'(k);
        MODE_REV:  src = LW'(NUM_LANES - 1 - k);
        MODE_ROT:  src = LW'((k + 1) % NUM_LANES);
        default:   src = '0;
      endcase
    end

    assign xf_pkd[k]    = i_sig_pkd[src];
    assign xf_upk[k]    = i_sig_upk[src];
    assign o_sig_pkd[k] = head_vld ? mem_pkd[rd_ptr][k] : '0;
    assign o_sig_upk[k] = head_vld ? mem_upk[rd_ptr][k] : '0;
  end

  // Write the transformed payload into the slot at the write pointer.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_pkd[wr_ptr] <= xf_pkd;
      mem_upk[wr_ptr] <= xf_upk;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks
  // occupancy and is unchanged when a push and a pop coincide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sub3_lane_fifo.sv
// tb_sub3_lane_fifo: directed bench for sub3_lane_fifo with default
// parameters (3 lanes x 8 bits, depth 4, almost-full at 3).
module tb_sub3_lane_fifo;

  logic              clk;
  logic              rst_n;
  logic              in_vld;
  logic              in_rdy;
  logic [1:0]        mode;
  logic [0:2][7:0]   in_pkd;
  logic [7:0]        in_upk [0:2];
  logic              out_vld;
  logic              out_rdy;
  logic [0:2][7:0]   out_pkd;
  logic [7:0]        out_upk [0:2];
  logic [2:0]        cnt;
  logic              afull;

  int total = 0;
  int bad   = 0;

  sub3_lane_fifo #(.NUM_LANES(3), .LANE_W(8), .DEPTH(4), .AFULL_TH(3)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sig_vld  (in_vld),
    .o_sig_rdy  (in_rdy),
    .i_sig_mode (mode),
    .i_sig_pkd  (in_pkd),
    .i_sig_upk  (in_upk),
    .o_sig_vld  (out_vld),
    .i_sig_rdy  (out_rdy),
    .o_sig_pkd  (out_pkd),
    .o_sig_upk  (out_upk),
    .o_sig_cnt  (cnt),
    .o_sig_afull(afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's producer/consumer inputs; upk lanes given flattened.
  task automatic applyStimulus(input logic vld, input logic [1:0] m,
                               input logic [23:0] pkd, input logic [23:0] upk,
                               input logic rdy);
    in_vld    = vld;
    mode      = m;
    in_pkd    = pkd;
    in_upk[0] = upk[23:16];
    in_upk[1] = upk[15:8];
    in_upk[2] = upk[7:0];
    out_rdy   = rdy;
  endtask

  // Compare one observed value to its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [23:0] upkFlat();
    return {out_upk[0], out_upk[1], out_upk[2]};
  endfunction

  // Check the head entry and occupancy together.
  task automatic checkHead(input string tag, input logic [23:0] pkd,
                           input logic [23:0] upk, input logic [2:0] c);
    checkOutput({tag, "_vld"}, 32'(out_vld), 32'(c != 0));
    checkOutput({tag, "_pkd"}, 32'(out_pkd), 32'(pkd));
    checkOutput({tag, "_upk"}, 32'(upkFlat()), 32'(upk));
    checkOutput({tag, "_cnt"}, 32'(cnt), 32'(c));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 24'h0, 24'h0, 1'b0);
    #12;
    checkHead("rst", 24'h0, 24'h0, 3'd0);
    checkOutput("rst_rdy", 32'(in_rdy), 32'd1);
    checkOutput("rst_afull", 32'(afull), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single push in pass mode, then pop.
    applyStimulus(1'b1, 2'd0, 24'h112233, 24'h445566, 1'b0);
    step();
    applyStimulus(1'b0, 2'd0, 24'h0, 24'h0, 1'b0);
    checkHead("single", 24'h112233, 24'h445566, 3'd1);
    out_rdy = 1'b1;
    step();
    checkHead("single_pop", 24'h0, 24'h0, 3'd0);

    // Empty FIFO must not leak unknown inputs to the outputs.
    in_pkd = 'x;
    step();
    checkOutput("empty_x_pkd", 32'(out_pkd), 32'd0);

    // Mode sweep: reverse, rotate, broadcast.
    applyStimulus(1'b1, 2'd1, 24'hA1B2C3, 24'h0D0E0F, 1'b0);
    step();
    applyStimulus(1'b1, 2'd2, 24'hA1B2C3, 24'h0D0E0F, 1'b0);
    step();
    applyStimulus(1'b1, 2'd3, 24'hA1B2C3, 24'h0D0E0F, 1'b0);
    step();
    applyStimulus(1'b0, 2'd0, 24'h0, 24'h0, 1'b0);
    checkHead("mode_rev", 24'hC3B2A1, 24'h0F0E0D, 3'd3);
    checkOutput("mode_afull3", 32'(afull), 32'd1);
    out_rdy = 1'b1;
    step();
    checkHead("mode_rot", 24'hB2C3A1, 24'h0E0F0D, 3'd2);
    checkOutput("mode_afull2", 32'(afull), 32'd0);
    step();
    checkHead("mode_bcast", 24'hA1A1A1, 24'h0D0D0D, 3'd1);
    step();
    checkHead("mode_drain", 24'h0, 24'h0, 3'd0);

    // Fill to depth with the consumer stalled, entries reversed on push.
    applyStimulus(1'b1, 2'd1, 24'h010203, 24'h818283, 1'b0);
    step();
    checkOutput("fill1_afull", 32'(afull), 32'd0);
    applyStimulus(1'b1, 2'd1, 24'h040506, 24'h848586, 1'b0);
    step();
    checkOutput("fill2_afull", 32'(afull), 32'd0);
    applyStimulus(1'b1, 2'd1, 24'h070809, 24'h878889, 1'b0);
    step();
    checkOutput("fill3_afull", 32'(afull), 32'd1);
    checkOutput("fill3_rdy", 32'(in_rdy), 32'd1);
    applyStimulus(1'b1, 2'd1, 24'h0A0B0C, 24'h8A8B8C, 1'b0);
    step();
    checkOutput("fill4_rdy", 32'(in_rdy), 32'd0);
    checkOutput("fill4_cnt", 32'(cnt), 32'd4);

    // Fifth push held while full; mode changes must not alter stored data.
    applyStimulus(1'b1, 2'd3, 24'h0D0E0F, 24'h8D8E8F, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkHead("full_hold", 24'h030201, 24'h838281, 3'd4);
    end

    // Release consumer: first edge pops only, second pushes and pops.
    applyStimulus(1'b1, 2'd0, 24'h0D0E0F, 24'h8D8E8F, 1'b1);
    step();
    checkHead("rel_e2", 24'h060504, 24'h868584, 3'd3);
    step();
    applyStimulus(1'b0, 2'd0, 24'h0, 24'h0, 1'b1);
    checkHead("rel_e3", 24'h090807, 24'h898887, 3'd3);
    step();
    checkHead("rel_e4", 24'h0C0B0A, 24'h8C8B8A, 3'd2);
    step();
    checkHead("rel_e5", 24'h0D0E0F, 24'h8D8E8F, 3'd1);
    step();
    checkHead("rel_empty", 24'h0, 24'h0, 3'd0);

    // Prefill two entries, then stream push+pop for 10 cycles.
    for (int n = 0; n < 2; n++) begin
      applyStimulus(1'b1, 2'd0, {8'(8'h50 + n), 8'(8'h90 + n), 8'(8'hD0 + n)},
                    {8'(n), 8'(8'h20 + n), 8'(8'h40 + n)}, 1'b0);
      step();
    end
    for (int n = 2; n < 12; n++) begin
      applyStimulus(1'b1, 2'd0, {8'(8'h50 + n), 8'(8'h90 + n), 8'(8'hD0 + n)},
                    {8'(n), 8'(8'h20 + n), 8'(8'h40 + n)}, 1'b1);
      step();
      checkHead("stream", {8'(8'h50 + n - 1), 8'(8'h90 + n - 1), 8'(8'hD0 + n - 1)},
                {8'(n - 1), 8'(8'h20 + n - 1), 8'(8'h40 + n - 1)}, 3'd2);
    end
    applyStimulus(1'b0, 2'd0, 24'h0, 24'h0, 1'b1);
    step();
    checkHead("stream_tail", 24'h5B9BDB, 24'h0B2B4B, 3'd1);
    step();

    // Asynchronous reset mid-cycle with three entries in flight.
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 2'd0, 24'h777777, 24'h333333, 1'b0);
      step();
    end
    applyStimulus(1'b0, 2'd0, 24'h0, 24'h0, 1'b0);
    checkOutput("pre_arst_cnt", 32'(cnt), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkHead("arst", 24'h0, 24'h0, 3'd0);
    checkOutput("arst_rdy", 32'(in_rdy), 32'd1);
    checkOutput("arst_afull", 32'(afull), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkHead("post_arst", 24'h0, 24'h0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
